bin_to_bcd_seq: RTL

Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It generalises the fixed 32-bit, 8-digit converter to any input width and digit count, and adds:
- optional two's-complement signed mode;
- valid/ready handshakes on input and output;
- overflow detection;
- a significant-digit count for display blanking.

It sits between arithmetic/datapath blocks and the 7-segment display drivers.

---
 rtl/bin_to_bcd_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per cycle,
// with optional two's-complement input, valid/ready handshakes and overflow flag.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH  = 32,
    parameter int DIGITS    = 10,
    parameter int SIGNED_EN = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_WIDTH-1:0]             in_data,
    input  logic                            in_signed,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [4*DIGITS-1:0]             out_bcd,
    output logic                            out_neg,
    output logic                            out_ovf,
    output logic [$clog2(DIGITS+1)-1:0]     out_ndigits
);

    localparam int NDW = $clog2(DIGITS + 1);
    localparam int CW  = $clog2(IN_WIDTH);

    if (IN_WIDTH < 4 || IN_WIDTH > 64) begin : g_bad_width
        $error("bin_to_bcd_seq: IN_WIDTH must be in 4..64");
    end
    if (DIGITS < 1 || DIGITS > 20) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS must be in 1..20");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IN_WIDTH-1:0]    bin_q;
    logic [4*DIGITS-1:0]    acc_q;
    logic                   ovf_q;
    logic                   neg_q;
    logic [CW-1:0]          cnt_q;

    logic                   out_valid_q;
    logic [4*DIGITS-1:0]    out_bcd_q;
    logic                   out_neg_q;
    logic                   out_ovf_q;
    logic [NDW-1:0]         out_ndigits_q;

    logic [4*DIGITS-1:0]    acc_adj;
    logic [4*DIGITS-1:0]    acc_d;
    logic [IN_WIDTH-1:0]    bin_d;
    logic                   ovf_d;
    logic [NDW-1:0]         nd_d;
    logic                   neg_in;
    logic [IN_WIDTH-1:0]    mag_in;

    // Magnitude of the incoming operand; the most-negative value maps to 2^(IN_WIDTH-1).
    always_comb begin
        neg_in = (SIGNED_EN != 0) && in_signed && in_data[IN_WIDTH-1];
        mag_in = neg_in ? ((~in_data) + IN_WIDTH'(1)) : in_data;
    end

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_d = {acc_adj[4*DIGITS-2:0], bin_q[IN_WIDTH-1]};
        bin_d = bin_q << 1;
        ovf_d = ovf_q | acc_adj[4*DIGITS-1];
        nd_d  = NDW'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (acc_d[4*i +: 4] != 4'd0) begin
                nd_d = NDW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            out_valid_q   <= 1'b0;
            out_bcd_q     <= '0;
            out_neg_q     <= 1'b0;
            out_ovf_q     <= 1'b0;
            out_ndigits_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        bin_q   <= mag_in;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        neg_q   <= neg_in;
                        cnt_q   <= '0;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    bin_q <= bin_d;
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(IN_WIDTH - 1)) begin
                        out_bcd_q     <= acc_d;
                        out_neg_q     <= neg_q;
                        out_ovf_q     <= ovf_d;
                        out_ndigits_q <= nd_d;
                        out_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE) && !reset;
    assign out_valid   = out_valid_q;
    assign out_bcd     = out_bcd_q;
    assign out_neg     = out_neg_q;
    assign out_ovf     = out_ovf_q;
    assign out_ndigits = out_ndigits_q;

endmodule
